// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pipe : registered ALU, valid/ready in and out, persistent {V,N,Z}       |
// | Optional iterative multiplier on opcode 1100 when ALU_PIPE_MUL_EN is defined|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_err,
  output logic [2:0]       flags
);

  localparam logic [3:0] c_OP_ADD    = 4'b0000;
  localparam logic [3:0] c_OP_SUB    = 4'b0001;
  localparam logic [3:0] c_OP_XOR    = 4'b0010;
  localparam logic [3:0] c_OP_RED    = 4'b0011;
  localparam logic [3:0] c_OP_SLL    = 4'b0100;
  localparam logic [3:0] c_OP_SRA    = 4'b0101;
  localparam logic [3:0] c_OP_ROR    = 4'b0110;
  localparam logic [3:0] c_OP_PADDSB = 4'b0111;
  localparam logic [3:0] c_OP_LW     = 4'b1000;
  localparam logic [3:0] c_OP_SW     = 4'b1001;
  localparam logic [3:0] c_OP_LLB    = 4'b1010;
  localparam logic [3:0] c_OP_LHB    = 4'b1011;
  localparam logic [3:0] c_OP_MUL    = 4'b1100;

  localparam logic [WIDTH-1:0] c_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int c_NB = WIDTH / 8;
  localparam int c_RW = 8 + $clog2(2 * c_NB);

  logic             r_out_valid, r_err;
  logic [WIDTH-1:0] r_out;
  logic [2:0]       r_flags;

  logic             w_accept, w_is_mul, w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_add, w_sub, w_add_sat, w_sub_sat, w_addr;
  logic             w_add_ov, w_sub_ov;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sll, w_sra, w_ror, w_paddsb, w_llb, w_lhb, w_red_ext;
  logic [2*WIDTH-1:0] w_ror2;
  logic signed [c_RW-1:0] w_red;

  logic [WIDTH-1:0] w_res, w_ld_res;
  logic             w_err, w_v, w_upd_z, w_upd_n, w_upd_v;
  logic             w_load, w_ld_err, w_ld_v, w_ld_upd_z, w_ld_upd_n, w_ld_upd_v;

  assign w_accept = in_valid & in_ready;

  // Saturating add/sub: overflow clamps toward the sign of operand1
  assign w_add     = operand1 + operand2;
  assign w_sub     = operand1 - operand2;
  assign w_add_ov  = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (w_add[WIDTH-1] != operand1[WIDTH-1]);
  assign w_sub_ov  = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (w_sub[WIDTH-1] != operand1[WIDTH-1]);
  assign w_add_sat = w_add_ov ? (operand1[WIDTH-1] ? c_SMIN : c_SMAX) : w_add;
  assign w_sub_sat = w_sub_ov ? (operand1[WIDTH-1] ? c_SMIN : c_SMAX) : w_sub;

  assign w_shamt = operand2[SHW-1:0];
  assign w_sll   = operand1 << w_shamt;
  assign w_sra   = WIDTH'($signed(operand1) >>> w_shamt);
  assign w_ror2  = {operand1, operand1} >> w_shamt;
  assign w_ror   = w_ror2[WIDTH-1:0];
  assign w_addr  = {operand1[WIDTH-1:1], 1'b0} + {operand2[WIDTH-2:0], 1'b0};

  for (genvar g = 0; g < WIDTH / 4; g++) begin : g_paddsb
    logic [3:0] w_a, w_b, w_s;
    logic       w_ov;
    assign w_a  = operand1[4*g +: 4];
    assign w_b  = operand2[4*g +: 4];
    assign w_s  = w_a + w_b;
    assign w_ov = (w_a[3] == w_b[3]) && (w_s[3] != w_a[3]);
    assign w_paddsb[4*g +: 4] = w_ov ? (w_a[3] ? 4'h8 : 4'h7) : w_s;
  end

  always_comb begin
    w_red = '0;
    for (int i = 0; i < c_NB; i++) begin
      w_red = w_red + c_RW'($signed(operand1[8*i +: 8])) + c_RW'($signed(operand2[8*i +: 8]));
    end
  end
  assign w_red_ext = WIDTH'(w_red);

  always_comb begin
    w_llb      = operand1;
    w_llb[7:0] = operand2[7:0];
  end

  if (WIDTH >= 16) begin : g_lhb_wide
    always_comb begin
      w_lhb       = operand1;
      w_lhb[15:8] = operand2[7:0];
    end
  end else begin : g_lhb_narrow
    assign w_lhb = operand1;
  end

  always_comb begin
    w_res   = '0;
    w_err   = 1'b0;
    w_v     = 1'b0;
    w_upd_z = 1'b0;
    w_upd_n = 1'b0;
    w_upd_v = 1'b0;
    case (opcode)
      c_OP_ADD:    begin w_res = w_add_sat; w_v = w_add_ov; w_upd_z = 1'b1; w_upd_n = 1'b1; w_upd_v = 1'b1; end
      c_OP_SUB:    begin w_res = w_sub_sat; w_v = w_sub_ov; w_upd_z = 1'b1; w_upd_n = 1'b1; w_upd_v = 1'b1; end
      c_OP_XOR:    begin w_res = operand1 ^ operand2; w_upd_z = 1'b1; end
      c_OP_RED:    w_res = w_red_ext;
      c_OP_SLL:    begin w_res = w_sll; w_upd_z = 1'b1; end
      c_OP_SRA:    begin w_res = w_sra; w_upd_z = 1'b1; end
      c_OP_ROR:    begin w_res = w_ror; w_upd_z = 1'b1; end
      c_OP_PADDSB: w_res = w_paddsb;
      c_OP_LW,
      c_OP_SW:     w_res = w_addr;
      c_OP_LLB:    w_res = w_llb;
      c_OP_LHB:    w_res = w_lhb;
      default:     w_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam logic c_IDLE = 1'b0;
  localparam logic c_BUSY = 1'b1;
  localparam int   c_CW   = $clog2(WIDTH);

  logic             r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [c_CW-1:0]  r_cnt;

  assign w_is_mul   = (opcode == c_OP_MUL);
  assign w_mul_res  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = (r_state == c_BUSY) && (r_cnt == c_CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept && w_is_mul) w_state_nxt = c_BUSY;
      c_BUSY:  if (w_mul_done) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == c_IDLE) && (!r_out_valid || out_ready);
  end

  // Shift-add: multiplicand moves left, multiplier right, one bit per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= operand1;
      r_mplier <= operand2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == c_BUSY) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_mul_res;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign in_ready   = !r_out_valid || out_ready;
`endif

  always_comb begin
    w_load     = w_accept && !w_is_mul;
    w_ld_res   = w_res;
    w_ld_err   = w_err;
    w_ld_v     = w_v;
    w_ld_upd_z = w_upd_z;
    w_ld_upd_n = w_upd_n;
    w_ld_upd_v = w_upd_v;
    if (w_mul_done) begin
      w_load     = 1'b1;
      w_ld_res   = w_mul_res;
      w_ld_err   = 1'b0;
      w_ld_v     = 1'b0;
      w_ld_upd_z = 1'b1;
      w_ld_upd_n = 1'b1;
      w_ld_upd_v = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_flags     <= 3'b000;
    end else if (w_load) begin
      r_out       <= w_ld_res;
      r_out_valid <= 1'b1;
      r_err       <= w_ld_err;
      if (w_ld_upd_z) r_flags[0] <= (w_ld_res == '0);
      if (w_ld_upd_n) r_flags[1] <= w_ld_res[WIDTH-1];
      if (w_ld_upd_v) r_flags[2] <= w_ld_v;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign alu_out   = r_out;
  assign out_valid = r_out_valid;
  assign out_err   = r_err;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// Directed testbench for alu_pipe at WIDTH=16; MUL cases follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]    opcode;
  logic [W-1:0]  operand1, operand2, alu_out;
  logic [2:0]    flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .out_err   (out_err),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one op for a single clock, returns at the next negedge
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] res, input logic [2:0] flg, input logic err);
    check({tag, ".valid"}, 16'(out_valid), 16'd1);
    check({tag, ".res"},   alu_out,        res);
    check({tag, ".flags"}, 16'(flags),     16'(flg));
    check({tag, ".err"},   16'(out_err),   16'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic seen;
    in_valid  = 1'b0;
    opcode    = 4'h0;
    operand1  = '0;
    operand2  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid",    16'(out_valid), 16'd0);
    check("rst.res",      alu_out,        16'h0000);
    check("rst.err",      16'(out_err),   16'd0);
    check("rst.flags",    16'(flags),     16'd0);
    check("rst.in_ready", 16'(in_ready),  16'd1);
    rst = 1'b1;
    @(negedge clk);

    issue("add_pos_ov", 4'b0000, 16'h7FFF, 16'h0001); expect_res("add_pos_ov", 16'h7FFF, 3'b100, 1'b0);
    issue("sub_zero",   4'b0001, 16'h0005, 16'h0005); expect_res("sub_zero",   16'h0000, 3'b001, 1'b0);
    issue("paddsb_pos", 4'b0111, 16'h7777, 16'h1111); expect_res("paddsb_pos", 16'h7777, 3'b001, 1'b0);
    issue("paddsb_neg", 4'b0111, 16'h8888, 16'h8888); expect_res("paddsb_neg", 16'h8888, 3'b001, 1'b0);
    issue("sub_neg_ov", 4'b0001, 16'h8000, 16'h0001); expect_res("sub_neg_ov", 16'h8000, 3'b110, 1'b0);
    issue("xor_zero",   4'b0010, 16'h00FF, 16'h00FF); expect_res("xor_zero",   16'h0000, 3'b111, 1'b0);
    issue("red",        4'b0011, 16'h0102, 16'h0304); expect_res("red",        16'h000A, 3'b111, 1'b0);
    issue("sra",        4'b0101, 16'h8000, 16'h0003); expect_res("sra",        16'hF000, 3'b110, 1'b0);
    issue("ror1",       4'b0110, 16'h0001, 16'h0001); expect_res("ror1",       16'h8000, 3'b110, 1'b0);
    issue("ror0",       4'b0110, 16'h1234, 16'h0010); expect_res("ror0",       16'h1234, 3'b110, 1'b0);
    issue("sll0",       4'b0100, 16'h1234, 16'h0000); expect_res("sll0",       16'h1234, 3'b110, 1'b0);
    issue("lw",         4'b1000, 16'h1001, 16'h0002); expect_res("lw",         16'h1004, 3'b110, 1'b0);
    issue("sw_wrap",    4'b1001, 16'hFFFF, 16'h8001); expect_res("sw_wrap",    16'h0000, 3'b110, 1'b0);
    issue("llb",        4'b1010, 16'hABCD, 16'h0012); expect_res("llb",        16'hAB12, 3'b110, 1'b0);
    issue("lhb",        4'b1011, 16'hABCD, 16'h0034); expect_res("lhb",        16'h34CD, 3'b110, 1'b0);
    issue("illegal",    4'b1110, 16'h1234, 16'h5678); expect_res("illegal",    16'h0000, 3'b110, 1'b1);
    issue("add_clr",    4'b0000, 16'h0001, 16'h0001); expect_res("add_clr",    16'h0002, 3'b000, 1'b0);
    issue("add_negsum", 4'b0000, 16'hFFFF, 16'hFFFF); expect_res("add_negsum", 16'hFFFE, 3'b010, 1'b0);
    issue("add_neg_ov", 4'b0000, 16'h8000, 16'hFFFF); expect_res("add_neg_ov", 16'h8000, 3'b110, 1'b0);

    // Backpressure: drain, then hold a result with out_ready low
    @(negedge clk);
    check("drain.valid", 16'(out_valid), 16'd0);
    out_ready = 1'b0;
    issue("bp_add", 4'b0000, 16'h0010, 16'h0020); expect_res("bp_add", 16'h0030, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold.res",      alu_out,        16'h0030);
      check("bp_hold.in_ready", 16'(in_ready),  16'd0);
      check("bp_hold.valid",    16'(out_valid), 16'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue("bp_sll", 4'b0100, 16'h0001, 16'h000F); expect_res("bp_sll", 16'h8000, 3'b000, 1'b0);

`ifdef ALU_PIPE_MUL_EN
    issue("mul", 4'b1100, 16'h0003, 16'h0005);
    check("mul.busy_in_ready", 16'(in_ready),  16'd0);
    check("mul.busy_valid",    16'(out_valid), 16'd0);
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("mul.latency", 16'(cnt), 16'd17);
    expect_res("mul", 16'h000F, 3'b000, 1'b0);

    issue("presub", 4'b0001, 16'h8000, 16'h0001); expect_res("presub", 16'h8000, 3'b110, 1'b0);
    issue("mul_abort", 4'b1100, 16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
`else
    issue("mul_illegal", 4'b1100, 16'h0003, 16'h0005); expect_res("mul_illegal", 16'h0000, 3'b000, 1'b1);
    issue("mul_clr",     4'b0000, 16'h0001, 16'h0001); expect_res("mul_clr",     16'h0002, 3'b000, 1'b0);
    issue("presub", 4'b0001, 16'h8000, 16'h0001); expect_res("presub", 16'h8000, 3'b110, 1'b0);
`endif

    rst = 1'b0;
    #1;
    check("areset.valid", 16'(out_valid), 16'd0);
    check("areset.flags", 16'(flags),     16'd0);
    check("areset.res",   alu_out,        16'h0000);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("areset.no_valid", 16'(seen),     16'd0);
    check("areset.in_ready", 16'(in_ready), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
